// File: rtl/spi_target.sv
// spi_target: SPI mode-3 (CPOL=1, CPHA=1) responder that models a
// register-mapped sensor. A frame is CS low, 16 SPC cycles, MSB first:
// RW (1=read), AD6..AD0, then D7..D0. The register file is also reachable
// from a local port for loopback and for bench preloading.
//
// Parameters:
//   NUM_REGS  registers at addresses 0..NUM_REGS-1 (1..128)
//   ID_ADDR   address of the read-only ID register
//   ID_VAL    value returned at ID_ADDR
//
// Ports:
//   clk, reset        system clock (>= 8x SPC), asynchronous active-high reset
//   SPC, CS, SDI      SPI clock (idles high), chip select (active low), data in
//   SDO               SPI data out; 0 outside the data phase of a read
//   laddr/lwe/lwdata  local register write port (one clk per write)
//   lrdata            combinational read of regs[laddr]
//   wr_stb            1-clk pulse when an SPI write commits
//   wr_addr, wr_data  address and data of the last SPI write
//   frame_err         1-clk pulse when CS rises in the middle of a frame
//   state_dbg         current FSM state (IDLE=0, CMD=1, DATA=2, HOLD=3)
//
// Build option: define SPI_TGT_AUTOINC_EN for multi-byte frames with the
// address incrementing (mod 128) after every data byte.

module spi_target #(
   parameter int         NUM_REGS = 64,
   parameter logic [6:0] ID_ADDR  = 7'h0F,
   parameter logic [7:0] ID_VAL   = 8'h33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SPC,
   input  logic       CS,
   input  logic       SDI,
   output logic       SDO,
   input  logic [6:0] laddr,
   input  logic       lwe,
   input  logic [7:0] lwdata,
   output logic [7:0] lrdata,
   output logic       wr_stb,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_err,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      state_q, state_nx;
   logic        frame_err_nx;
   logic        cmd_last;       // 8th rise of the command byte
   logic        data_last;      // 8th rise of a data byte
   logic        data_partial;   // CS rise now would cut a data byte short

   logic        spc_s1, spc_s2, spc_d;
   logic        cs_s1, cs_s2, cs_d;
   logic        sdi_s1, sdi_s2;
   logic        primed_q, armed_q;
   logic        spc_rise, spc_fall, cs_fall;

   logic [2:0]  bit_cnt_q;
   logic [6:0]  sh_q;           // last seven sampled SDI bits
   logic        rw_q;
   logic [6:0]  addr_q;
   logic [7:0]  tx_q;
   logic [6:0]  cmd_addr;
   logic [7:0]  rx_byte;
   logic [7:0]  regs [128];
`ifdef SPI_TGT_AUTOINC_EN
   logic        multi_q;        // at least one data byte of this frame completed
`endif

   function automatic logic in_range(input logic [6:0] a);
      return (int'(a) < NUM_REGS);
   endfunction

   function automatic logic writable(input logic [6:0] a);
      return in_range(a) && (a != ID_ADDR);
   endfunction

   function automatic logic [7:0] reg_value(input logic [6:0] a);
      if (a == ID_ADDR)
         return ID_VAL;
      else if (in_range(a))
         return regs[a];
      else
         return 8'h00;
   endfunction

   // Synchronizers reset to the idle bus (SPC=1, CS=1). armed_q only goes
   // high once a real CS-high level has been seen after reset, so a CS that
   // is still low from an interrupted frame cannot start a new one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spc_s1   <= 1'b1;
         spc_s2   <= 1'b1;
         spc_d    <= 1'b1;
         cs_s1    <= 1'b1;
         cs_s2    <= 1'b1;
         cs_d     <= 1'b1;
         sdi_s1   <= 1'b0;
         sdi_s2   <= 1'b0;
         primed_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         spc_s1   <= SPC;
         spc_s2   <= spc_s1;
         spc_d    <= spc_s2;
         cs_s1    <= CS;
         cs_s2    <= cs_s1;
         cs_d     <= cs_s2;
         sdi_s1   <= SDI;
         sdi_s2   <= sdi_s1;
         primed_q <= 1'b1;
         if (primed_q && cs_s1)
            armed_q <= 1'b1;
      end
   end

   assign spc_rise = spc_s2 & ~spc_d;
   assign spc_fall = ~spc_s2 & spc_d;
   assign cs_fall  = armed_q & cs_d & ~cs_s2;
   assign cmd_addr = {sh_q[5:0], sdi_s2};
   assign rx_byte  = {sh_q, sdi_s2};

`ifdef SPI_TGT_AUTOINC_EN
   // Ending the frame right after a completed byte is a clean stop.
   assign data_partial = (bit_cnt_q != 3'd0) || !multi_q;
`else
   assign data_partial = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_nx;
   end

   // CS high overrides everything, including an SPC edge in the same clk.
   always_comb begin
      state_nx     = state_q;
      frame_err_nx = 1'b0;
      cmd_last     = 1'b0;
      data_last    = 1'b0;
      if (cs_s2) begin
         state_nx = IDLE;
         if ((state_q == CMD && bit_cnt_q != 3'd0) || (state_q == DATA && data_partial))
            frame_err_nx = 1'b1;
      end else begin
         case (state_q)
            IDLE: if (cs_fall) state_nx = CMD;
            CMD: begin
               if (spc_rise && bit_cnt_q == 3'd7) begin
                  cmd_last = 1'b1;
                  state_nx = DATA;
               end
            end
            DATA: begin
               if (spc_rise && bit_cnt_q == 3'd7) begin
                  data_last = 1'b1;
`ifdef SPI_TGT_AUTOINC_EN
                  state_nx  = DATA;
`else
                  state_nx  = HOLD;
`endif
               end
            end
            HOLD:    state_nx = HOLD;
            default: state_nx = IDLE;
         endcase
      end
   end

   assign state_dbg = state_q;

   // wr_stb and frame_err are single-clk strobes with no back-pressure: a
   // consumer that cares must capture them in the clk they are high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt_q <= 3'd0;
         sh_q      <= 7'd0;
         rw_q      <= 1'b0;
         addr_q    <= 7'd0;
         tx_q      <= 8'h00;
         SDO       <= 1'b0;
         wr_stb    <= 1'b0;
         wr_addr   <= 7'd0;
         wr_data   <= 8'h00;
         frame_err <= 1'b0;
`ifdef SPI_TGT_AUTOINC_EN
         multi_q   <= 1'b0;
`endif
         for (int i = 0; i < 128; i++)
            regs[i] <= 8'h00;
      end else begin
         wr_stb    <= 1'b0;
         frame_err <= frame_err_nx;

         // Counter wraps 7->0 at the end of each byte.
         if (cs_s2 || state_q == IDLE || state_q == HOLD)
            bit_cnt_q <= 3'd0;
         else if (spc_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            sh_q      <= {sh_q[5:0], sdi_s2};
         end

         // Read data leaves on SPC falls; the byte to send was captured at
         // the preceding 8th rise, so later local writes cannot disturb it.
         if (state_q == DATA && rw_q && !cs_s2) begin
            if (spc_fall) begin
               SDO  <= tx_q[7];
               tx_q <= {tx_q[6:0], 1'b0};
            end
         end else begin
            SDO <= 1'b0;
         end

         if (cmd_last) begin
            rw_q   <= sh_q[6];
            addr_q <= cmd_addr;
            if (sh_q[6])
               tx_q <= reg_value(cmd_addr);
         end

         // Local write first so an SPI write to the same address wins.
         if (lwe && writable(laddr))
            regs[laddr] <= lwdata;

         if (data_last) begin
            if (!rw_q) begin
               wr_stb  <= 1'b1;
               wr_addr <= addr_q;
               wr_data <= rx_byte;
               if (writable(addr_q))
                  regs[addr_q] <= rx_byte;
            end
`ifdef SPI_TGT_AUTOINC_EN
            addr_q  <= addr_q + 7'd1;
            multi_q <= 1'b1;
            if (rw_q)
               tx_q <= reg_value(addr_q + 7'd1);
`endif
         end

`ifdef SPI_TGT_AUTOINC_EN
         if (state_q != DATA)
            multi_q <= 1'b0;
`endif
      end
   end

   always_comb begin
      lrdata = 8'h00;
      if (laddr == ID_ADDR)
         lrdata = ID_VAL;
      else if (in_range(laddr))
         lrdata = regs[laddr];
   end

endmodule
